// File: rtl/mux32_rr_arbiter_pkg.sv
// Shared state encodings and requester indices for the two-way round-robin mux arbiter.
package mux32_rr_arbiter_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mux32_rr_arbiter_mux.sv
// Byte-sliced 2-to-1 word muxes: select=0 passes in1, select=1 passes in2.
module Mux8Bit_2To1 (
  output logic [7:0] out,
  input  logic       select,
  input  logic [7:0] in1,
  input  logic [7:0] in2
);
  assign out = select ? in2 : in1;
endmodule

module Mux32Bit_2To1 (
  output logic [31:0] out,
  input  logic        select,
  input  logic [31:0] in1,
  input  logic [31:0] in2
);
  for (genvar i = 0; i < 4; i++) begin : g_slice
    Mux8Bit_2To1 u_slice (
      .out    (out[i*8 +: 8]),
      .select (select),
      .in1    (in1[i*8 +: 8]),
      .in2    (in2[i*8 +: 8])
    );
  end
endmodule

// File: rtl/mux32_rr_arbiter_pick.sv
// Combinational two-way round-robin picker; on a tie the requester not granted last wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic winner,
  output logic any_req
);
  import mux32_rr_arbiter_pkg::*;

  always_comb begin
    winner = REQ0;
    if (req0 && req1) winner = ~last_grant;
    else if (req1)    winner = REQ1;
    any_req = req0 | req1;
  end
endmodule

// File: rtl/mux32_rr_arbiter.sv
// Two requesters share one word mux into a single-entry output register drained by valid/ready.
module mux32_rr_arbiter #(
  parameter int WIDTH      = 32,
  parameter int FIRST_PRIO = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt1,
  output logic             mux_sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);
  import mux32_rr_arbiter_pkg::*;

  // Seeding last_grant with the opposite index makes FIRST_PRIO win the first tie.
  localparam logic LAST_GRANT_RST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

  if (WIDTH % 8 != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of 8");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_src_q, out_src_d;
  logic             last_grant_q, last_grant_d;

  logic             winner, any_req, can_accept, grant;
  logic [WIDTH-1:0] mux_out;

  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  // With no request pending the select parks on the last winner instead of toggling.
  assign mux_sel = any_req ? winner : last_grant_q;

  if (WIDTH == 32) begin : g_mux32
    Mux32Bit_2To1 u_mux (
      .out    (mux_out),
      .select (mux_sel),
      .in1    (data0),
      .in2    (data1)
    );
  end else begin : g_mux_slices
    for (genvar i = 0; i < WIDTH / 8; i++) begin : g_slice
      Mux8Bit_2To1 u_slice (
        .out    (mux_out[i*8 +: 8]),
        .select (mux_sel),
        .in1    (data0[i*8 +: 8]),
        .in2    (data1[i*8 +: 8])
      );
    end
  end

  assign out_valid  = (state_q == FULL);
  assign can_accept = (state_q == EMPTY) | (out_valid & out_ready);
  assign gnt0       = ~reset & can_accept & req0 & (winner == REQ0);
  assign gnt1       = ~reset & can_accept & req1 & (winner == REQ1);
  assign grant      = gnt0 | gnt1;
  assign out_data   = out_data_q;
  assign out_src    = out_src_q;

  // A load on the same edge as a drain keeps the register FULL for 1 word/cycle.
  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    if (grant) begin
      state_d      = FULL;
      out_data_d   = mux_out;
      out_src_d    = winner;
      last_grant_d = winner;
    end else if (out_valid && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      out_data_q   <= '0;
      out_src_q    <= 1'b0;
      last_grant_q <= LAST_GRANT_RST;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: doc/mux32_rr_arbiter.md
Name: mux32_rr_arbiter

Overview:
- Shares one 32-bit 2-to-1 mux datapath between two requesters using round-robin arbitration.
- Each requester presents a word with a req/gnt handshake. The winner's word passes through the mux into a one-entry output register, which is drained by a valid/ready consumer.
- Sits between two producer blocks and a single downstream 32-bit sink.
- Drives the mux select so the datapath mux is never steered by the requesters directly.

Parameters:
- WIDTH, 32, data word width. Must be a multiple of 8 so the mux is built from 8-bit slices.
- FIRST_PRIO, 0, requester that wins the first tie after reset (0 or 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 has a word pending. Held until gnt0.
- data0  input  WIDTH  requester 0 word. Stable while req0 is high.
- gnt0  output  1  combinational. Transfer from requester 0 occurs this cycle.
- req1  input  1  requester 1 has a word pending.
- data1  input  WIDTH  requester 1 word.
- gnt1  output  1  combinational grant to requester 1.
- mux_sel  output  1  datapath select. 0 = data0, 1 = data1.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered word.
- out_src  output  1  source index of out_data.
- out_ready  input  1  sink accepts out_data this cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset; all state clears immediately on assertion, independent of clk.
- Reset values:
  - out_valid=0, out_data=0, out_src=0.
  - FSM=EMPTY.
  - last_grant=~FIRST_PRIO.
  - gnt0/gnt1 are forced 0 while reset is high.
- FSM has two states:
  - EMPTY: output register empty.
  - FULL: output register holds a word.
- Capacity signal: can_accept = (state==EMPTY) | (out_valid & out_ready).
- Winner selection:
  - Only req0 high: winner=0.
  - Only req1 high: winner=1.
  - Both high: winner=~last_grant.
  - Neither high: no winner, and mux_sel holds last_grant.
- Grants:
  - gnt0 = can_accept & req0 & winner==0.
  - gnt1 = can_accept & req1 & winner==1.
  - At most one grant is high in any cycle.
- mux_sel = winner whenever any request is high, so it is valid in the same cycle as the grant.
- On a clock edge with a grant high:
  - out_data <= mux output.
  - out_src <= winner.
  - last_grant <= winner.
  - state <= FULL.
- On a clock edge with out_valid & out_ready and no grant: state <= EMPTY, out_data holds its value.
- Simultaneous drain and grant: the drain and the load happen on the same edge and state stays FULL. This gives full throughput of 1 word/cycle.
- FULL with out_ready=0: no grants are issued, requesters stall, and last_grant is unchanged.
- Latency: a word appears on out_data the cycle after its grant.
- Fairness: with both requesters continuously asserting, grants alternate strictly 0,1,0,1. Neither requester waits more than one transfer.
- out_valid = (state==FULL).
- last_grant only changes on a transfer. An idle cycle does not rotate priority.
- Reset mid-operation: any pending word in the output register is discarded. Requesters keep req asserted and are re-served after reset, starting from FIRST_PRIO on a tie.
- Requester protocol violations are not checked and may be flagged by bench assertions:
  - req dropped before gnt.
  - data changed while req is high.

Decomposition:
- Shared include/constants file: state encodings EMPTY=1'b0 and FULL=1'b1, plus requester index constants REQ0=0 and REQ1=1.
- Datapath: instantiate the existing Mux32Bit_2To1 for WIDTH=32. Port order is (out, select, in1, in2), with in1=data0 and in2=data1.
- One natural sub-module, rr_pick2: a combinational round-robin picker.
  - Inputs: req0, req1, last_grant.
  - Outputs: winner, any_req.
  - Reusable by other two-way arbiters.
- The top level holds the FSM, the output register and the grant gating.

Test Plan:
- Reset then idle: reset pulsed, no reqs → out_valid=0, gnt0=gnt1=0, out_data=0. Asserting reset asynchronously mid-cycle clears out_valid without waiting for a clk edge.
- Single requester: req0=1, data0=32'hAAAAAAAA, out_ready=1 → gnt0=1 in cycle 0, out_data=32'hAAAAAAAA with out_src=0 and out_valid=1 in cycle 1, mux_sel=0.
- Tie from reset: req0=req1=1, data0=32'hAAAAAAAA, data1=32'h55555555, out_ready=1 → grants alternate 0,1,0,1. out_data sequence is AAAAAAAA, 55555555, AAAAAAAA, … at one word/cycle.
- Backpressure: both reqs high, out_ready=0 after first load → out_valid stays 1, out_data holds 32'hAAAAAAAA, no gnt for 5 cycles. Raising out_ready then grants requester 1 in the same cycle, and 32'h55555555 appears the next cycle.
- Idle does not rotate: transfer from requester 1 then 3 idle cycles, then both req → requester 0 wins.
- Reset mid-operation: out_valid=1 holding 32'h55555555, reset asserted → out_valid=0 immediately. After release with both reqs high, requester 0 is granted first.
